// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared UART definitions used by both ends of the link (uart_tx, uart_rx):
//   FSM state encoding, the oversampling ratio, default frame geometry and
//   a parity helper. Keeping DEF_DBIT/DEF_SB_TICK here lets the transmitter
//   and receiver agree on frame shape without duplicated literals.
package uart_tx_pkg;

  // s_tick strobes per bit period
  localparam int OVERSAMPLE  = 16;

  // default frame: 8 data bits, 1 stop bit
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // FSM state encoding (3 bits, shared with the receiver)
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Parity over the low dbit bits of d; odd=1 flips the sense so that the
  // data bits plus the returned bit have an odd number of ones.
  function automatic logic par_bit(input logic [7:0] d, input int dbit,
                                   input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++)
      if (i < dbit) p = p ^ d[i];
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx
//   UART serial transmitter. One word is accepted per tx_start pulse while
//   idle and shifted out LSB-first as: start bit, DBIT data bits, optional
//   parity bit, stop period. All bit timing comes from s_tick (OVERSAMPLE
//   strobes per bit), the same strobe that drives uart_rx.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   s_tick       one-clk oversampling strobe
//   tx_start     one-clk send request, honoured only in idle
//   din[7:0]     word to send, captured on the accepted tx_start cycle
//   tx           serial line, registered, idle-high
//   tx_busy      high while a frame is in flight (registered with state)
//   tx_done_tick one-clk pulse on the final stop-period tick
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,    // 1..8 data bits
  parameter int SB_TICK = DEF_SB_TICK, // stop period in s_tick units (16/24/32)
  parameter int PAR_EN  = 0,           // 1: append parity bit
  parameter int PAR_ODD = 0            // parity sense: 0 even, 1 odd
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam logic [4:0] S_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
  localparam logic       ODD     = (PAR_ODD != 0);

  uart_state_t state_reg, state_next;
  logic [4:0]  s_reg, s_next;     // tick counter within the current bit
  logic [2:0]  n_reg, n_next;     // data bit index
  logic [7:0]  b_reg, b_next;     // shift register, b_reg[0] is on the line
  logic        p_reg, p_next;     // parity bit, fixed at acceptance
  logic        tx_reg, tx_next;
  logic        busy_reg;

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic. Without s_tick every counter holds, so the frame
  // simply stretches with the strobe rate.
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tx_start) begin
          // din is only looked at here; later changes cannot leak in
          b_next     = din;
          p_next     = par_bit(din, DBIT, ODD);
          s_next     = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST)
              state_next = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
            else
              n_next = n_reg + 3'd1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == S_LAST) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) state_next = ST_IDLE;
          else                  s_next     = s_reg + 5'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Output logic. The line level is decoded from the *next* state so tx
  // moves on the same edge as the state; b_next[0] is already the bit
  // that will be on the line after a shift.
  // --------------------------------------------------------------------
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b_next[0];
      ST_PARITY: tx_next = p_next;
      default:   tx_next = 1'b1;
    endcase
    tx_done_tick = (state_reg == ST_STOP) && s_tick && (s_reg == SB_LAST);
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Directed + randomized bench for uart_tx. Three instances share clk,
//   reset, s_tick and din: no parity, even parity, odd parity. The expected
//   line level is computed from the frame layout (tick index k since
//   acceptance -> bit slot k/16), not from any FSM model.
module tb_uart_tx;

  localparam int DB  = 8;
  localparam int SBT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [7:0] din;
  logic [2:0] tx_start;
  logic [2:0] tx, busy, done;

  int total = 0;
  int bad   = 0;
  bit rand_gap = 1'b0;
  int tcnt, tgap;

  int par_en  [3] = '{0, 1, 1};
  int par_odd [3] = '{0, 0, 1};

  always #5 clk = ~clk;

  uart_tx #(.DBIT(DB), .SB_TICK(SBT), .PAR_EN(0), .PAR_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din),
    .tx(tx[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx #(.DBIT(DB), .SB_TICK(SBT), .PAR_EN(1), .PAR_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din),
    .tx(tx[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx #(.DBIT(DB), .SB_TICK(SBT), .PAR_EN(1), .PAR_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[2]), .din(din),
    .tx(tx[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));

  // s_tick changes just after posedge, so at each negedge it shows the
  // strobe the next edge will consume. Fixed gap 4, or random 2..6.
  initial begin
    s_tick = 1'b0;
    tcnt = 0;
    tgap = 4;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      if (tcnt >= tgap) begin
        s_tick = 1'b1;
        tcnt   = 0;
        tgap   = rand_gap ? int'($urandom_range(6, 2)) : 4;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frame_ticks(input int d);
    return 16 * (1 + DB + par_en[d]) + SBT;
  endfunction

  // Line level after k consumed ticks of a frame carrying w.
  function automatic logic exp_line(input int d, input logic [7:0] w, input int k);
    int idx;
    if (k >= 16 * (1 + DB + par_en[d])) return 1'b1;
    idx = k / 16;
    if (idx == 0)  return 1'b0;
    if (idx <= DB) return w[idx-1];
    return (^w) ^ (par_odd[d] != 0);
  endfunction

  // Idle period: line high, not busy, no done pulse.
  task automatic idle(input int d, input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      tx_start[d] = 1'b0;
      chk("idle_tx", {7'd0, tx[d]}, 8'd1);
      chk("idle_busy", {7'd0, busy[d]}, 8'd0);
      chk("idle_done", {7'd0, done[d]}, 8'd0);
    end
  endtask

  // Send w on instance d and follow it cycle by cycle. Returns in the
  // tx_done_tick cycle so a following call starts back-to-back.
  // poke_mid/poke_done raise tx_start (din=11) mid-data / on the done cycle.
  // cut_k>=0 asserts reset between edges once k reaches cut_k.
  task automatic frame(input int d, input logic [7:0] w, input bit poke_mid,
                       input bit poke_done, input int cut_k);
    int k, n_tot, guard;
    logic [7:0] rx;
    n_tot = frame_ticks(d);
    k = 0;
    guard = 0;
    rx = 8'h00;
    @(negedge clk);
    chk("pre_tx", {7'd0, tx[d]}, 8'd1);
    chk("pre_busy", {7'd0, busy[d]}, 8'd0);
    tx_start[d] = 1'b1;
    din = w;
    forever begin
      @(negedge clk);
      tx_start[d] = 1'b0;
      din = 8'($urandom);
      if (cut_k >= 0 && k == cut_k) begin
        reset = 1'b1;
        #1;
        chk("rst_tx", {7'd0, tx[d]}, 8'd1);
        chk("rst_busy", {7'd0, busy[d]}, 8'd0);
        chk("rst_done", {7'd0, done[d]}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      chk("tx", {7'd0, tx[d]}, {7'd0, exp_line(d, w, k)});
      chk("busy", {7'd0, busy[d]}, 8'd1);
      chk("done", {7'd0, done[d]}, {7'd0, (s_tick && k == n_tot - 1)});
      // receiver-style mid-bit sampling of the data slots
      if (k % 16 == 8 && k >= 16 && k < 16 * (1 + DB)) rx[k/16 - 1] = tx[d];
      if (poke_mid && k == 16 * 3 + 5) begin
        tx_start[d] = 1'b1;
        din = 8'h11;
      end
      if (s_tick) begin
        if (k == n_tot - 1) begin
          if (poke_done) begin
            tx_start[d] = 1'b1;
            din = 8'h11;
          end
          chk("rx_word", rx, w);
          return;
        end
        k++;
      end
      guard++;
      if (guard > 20000) begin
        total++;
        bad++;
        $error("FAIL timeout: frame on dut%0d never completed, k=%0d need=%0d", d, k, n_tot);
        return;
      end
    end
  endtask

  initial begin
    int d;
    logic [7:0] w;
    reset = 1'b1;
    tx_start = '0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", {7'd0, tx[i]}, 8'd1);
      chk("reset_busy", {7'd0, busy[i]}, 8'd0);
      chk("reset_done", {7'd0, done[i]}, 8'd0);
    end
    reset = 1'b0;
    idle(0, 4);

    // basic frame, fixed 4-clk tick spacing
    frame(0, 8'hA5, 1'b0, 1'b0, -1);
    idle(0, 8);

    // words through the mid-bit sampler
    frame(0, 8'h3C, 1'b0, 1'b0, -1); idle(0, 5);
    frame(0, 8'hFF, 1'b0, 1'b0, -1); idle(0, 5);
    frame(0, 8'h00, 1'b0, 1'b0, -1); idle(0, 5);

    // parity even / odd
    frame(1, 8'h07, 1'b0, 1'b0, -1); idle(1, 5);
    frame(2, 8'h07, 1'b0, 1'b0, -1); idle(2, 5);

    // ignored requests mid-data and in the done cycle
    frame(0, 8'hA5, 1'b1, 1'b1, -1);
    idle(0, 40);

    // back-to-back
    frame(0, 8'hA5, 1'b0, 1'b0, -1);
    frame(0, 8'h55, 1'b0, 1'b0, -1);
    idle(0, 5);

    // reset during data bit 3, then a clean frame
    frame(0, 8'hA5, 1'b0, 1'b0, 16 * 4 + 6);
    idle(0, 5);
    frame(0, 8'h81, 1'b0, 1'b0, -1);
    idle(0, 5);

    // randomized words, instances, tick spacing and gaps
    rand_gap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(2, 0));
      w = 8'($urandom);
      frame(d, w, 1'($urandom_range(1, 0)), 1'b0, -1);
      if ($urandom_range(1, 0) == 1) idle(d, int'($urandom_range(10, 1)));
    end
    idle(0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
